// File: rtl/halt_pkg.sv
// Shared types and widths for the halt controller slice.
package halt_pkg;

  // Counter widths
  localparam int unsigned RETIRED_W = 32;
  localparam int unsigned TIMEOUT_W = 16;
  localparam int unsigned SETTLE_W  = 8;
  localparam int unsigned REASON_W  = 2;

  // Halt sequencing states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Reason code reported at end of run
  typedef enum logic [REASON_W-1:0] {
    HR_NONE    = 2'b00,
    HR_SC      = 2'b01,
    HR_TIMEOUT = 2'b10,
    HR_EXT     = 2'b11
  } reason_t;

endpackage : halt_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority; increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/halt_ctl.sv
// Halt sequencer: detects sc / external halt, freezes fetch, drains memory
// traffic, settles, then raises a sticky halt level for the clock block.
module halt_ctl
  import halt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned PC_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 retire_valid,
  input  logic                 retire_is_halt,
  input  logic [PC_W-1:0]      retire_pc,
  input  logic                 ext_halt_req,
  input  logic                 sb_empty,
  input  logic                 mem_busy,
  output logic                 freeze_fetch,
  output logic                 halt,
  output logic [REASON_W-1:0]  halt_reason,
  output logic [PC_W-1:0]      halt_pc,
  output logic [RETIRED_W-1:0] retired_count
);

  state_t              state_q, state_d;
  reason_t             reason_q, reason_d;
  logic [PC_W-1:0]     last_pc_q, last_pc_d;
  logic [PC_W-1:0]     halt_pc_q, halt_pc_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                freeze_q, freeze_d;
  logic                halt_q, halt_d;

  logic                 retire_cnt_en;
  logic                 timeout_clr;
  logic                 timeout_en;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 mem_idle;

  // Memory side is quiet when the store buffer is empty and nothing is in flight
  assign mem_idle = sb_empty & ~mem_busy;

  // Retired-instruction count, only advanced while running
  sat_counter #(.W(RETIRED_W)) u_retired_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (retire_cnt_en),
    .count (retired_count)
  );

  // Drain timeout: held at zero in RUN, advances every DRAIN cycle, frozen in SETTLE
  sat_counter #(.W(TIMEOUT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timeout_clr),
    .en    (timeout_en),
    .count (timeout_cnt)
  );

  // Next-state and next-value logic
  always_comb begin
    state_d       = state_q;
    reason_d      = reason_q;
    last_pc_d     = last_pc_q;
    halt_pc_d     = halt_pc_q;
    settle_d      = settle_q;
    retire_cnt_en = 1'b0;
    timeout_clr   = 1'b0;
    timeout_en    = 1'b0;

    case (state_q)
      RUN: begin
        timeout_clr = 1'b1;
        if (retire_valid) begin
          retire_cnt_en = 1'b1;
          last_pc_d     = retire_pc;
        end
        // A retiring sc beats a simultaneous external request
        if (retire_valid && retire_is_halt) begin
          halt_pc_d = retire_pc;
          reason_d  = HR_SC;
          state_d   = DRAIN;
        end else if (ext_halt_req) begin
          halt_pc_d = last_pc_q;
          reason_d  = HR_EXT;
          state_d   = DRAIN;
        end
      end

      DRAIN: begin
        // Retires seen here are squashed younger instructions: ignored
        timeout_en = 1'b1;
        if (mem_idle) begin
          settle_d = SETTLE_W'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end else if (timeout_cnt == TIMEOUT_W'(DRAIN_TIMEOUT - 1)) begin
          reason_d = HR_TIMEOUT;
          state_d  = HALTED;
        end
      end

      SETTLE: begin
        // A late store sends us back to DRAIN with the timeout still running
        if (!mem_idle) begin
          state_d = DRAIN;
        end else if (settle_q == SETTLE_W'(1)) begin
          settle_d = settle_q - SETTLE_W'(1);
          state_d  = HALTED;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      HALTED: begin
        // Terminal until reset
      end

      default: begin
        state_d = RUN;
      end
    endcase

    freeze_d = (state_d != RUN);
    halt_d   = (state_d == HALTED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      reason_q  <= HR_NONE;
      last_pc_q <= '0;
      halt_pc_q <= '0;
      settle_q  <= '0;
      freeze_q  <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      last_pc_q <= last_pc_d;
      halt_pc_q <= halt_pc_d;
      settle_q  <= settle_d;
      freeze_q  <= freeze_d;
      halt_q    <= halt_d;
    end
  end

  assign freeze_fetch = freeze_q;
  assign halt         = halt_q;
  assign halt_reason  = reason_q;
  assign halt_pc      = halt_pc_q;

endmodule : halt_ctl
